regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-register file: 2 read ports, 1 write port, optional hardwired zero register,
//  optional write->read bypass, and optional registered (1-cycle) reads. Carries an integrated
//  scoreboard: one pending bit per register, set when a producer issues and cleared at writeback.
//  Sits between decode/issue (Ra/Rb/Iss) and writeback (We/Wr/D) in the pipelined CPU datapath.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register index width; NREG = 2**ADDR_W registers
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never pending; 0: register 0 is ordinary
//  BYPASS   1   1: same-cycle write data forwarded to matching read port; 0: no forwarding
//  RD_REG   0   0: combinational read (latency 0); 1: read data/busy registered (latency 1)
// PORTS
//  Clk     in   1       clock, all state updates on rising edge
//  Clr     in   1       synchronous reset, active-high
//  Ra      in   ADDR_W  read port A index
//  Rb      in   ADDR_W  read port B index
//  Qa      out  DATA_W  read port A data
//  Qb      out  DATA_W  read port B data
//  Busy_a  out  1       register Ra has an outstanding producer (RAW hazard)
//  Busy_b  out  1       register Rb has an outstanding producer
//  We      in   1       write enable (writeback)
//  Wr      in   ADDR_W  write index
//  D       in   DATA_W  write data
//  Iss     in   1       issue strobe: mark register Wi pending
//  Wi      in   ADDR_W  index of register whose producer issues
//  Waw     out  1       comb.: Iss targets an already-pending register (Iss & pend[Wi])
//  Pend    out  NREG    pending-bit vector, bit i = register i
// BEHAVIOUR
//  - Clr=1 at rising edge: all registers 0, all pend bits 0, registered Qa/Qb/Busy_a/Busy_b 0.
//    Clr dominates We and Iss in the same cycle; a write or issue coinciding with Clr is lost.
//  - Write: rising edge with We=1, Clr=0: reg[Wr] <= D. Dropped if ZERO_REG=1 and Wr=0.
//  - Effective read value for index R: if BYPASS=1, We=1, Wr=R and not (ZERO_REG=1 & R=0) -> D;
//    else if ZERO_REG=1 and R=0 -> 0; else reg[R].
//  - RD_REG=0: Qa/Qb = effective value of Ra/Rb, combinational. Busy_x = pend[Rx], except that it
//    reads 0 when BYPASS=1 and the same-cycle write matches Rx.
//  - RD_REG=1: Qa/Qb/Busy_x capture the RD_REG=0 values at the rising edge; valid one cycle after
//    Ra/Rb are presented. With BYPASS=0 and a same-cycle write, the old value is captured.
//  - Scoreboard update at each rising edge with Clr=0, in this order: clear pend[Wr] if We; then set
//    pend[Wi] if Iss. Iss and We to the same index in one cycle leaves the bit SET (new producer).
//    Iss to an already-pending index: bit stays 1, Waw=1 that cycle. Nothing is counted.
//  - We to a non-pending register is legal: data is written, pend is unchanged (stays 0).
//  - ZERO_REG=1: pend[0] is constant 0. Iss with Wi=0 is ignored and Waw=0. Busy for index 0 is 0.
//  - Both read ports are independent; Ra=Rb is legal and returns identical data/busy.
//  - No X on any output after the first Clr edge. Before the first Clr, contents are undefined.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, Iss Wi=7, then Clr=1 for 1 cycle -> Ra=5 gives Qa=0, Pend=0, Busy_a=0.
//  2 Zero reg (ZERO_REG=1): We Wr=0 D=0x1234, Iss Wi=0 -> Ra=0 Qa=0, Pend[0]=0, Waw=0.
//  3 Bypass (BYPASS=1,RD_REG=0): r3=0x11; same cycle We Wr=3 D=0x22, Ra=3 -> Qa=0x22; next cycle still 0x22.
//    With BYPASS=0: same-cycle Qa=0x11, next cycle 0x22.
//  4 Scoreboard: Iss Wi=9 -> next cycle Pend[9]=1, Rb=9 Busy_b=1; Iss Wi=9 again -> Waw=1;
//    We Wr=9 D=0xAB (BYPASS=1) -> Busy_b=0 and Qb=0xAB that cycle; Pend[9]=0 after edge.
//  5 Simultaneous Iss Wi=4 and We Wr=4 with pend[4]=1 -> pend[4]=1 after edge, reg[4]=D.
//  6 Registered reads (RD_REG=1): r12=0x5A5A5A5A; Ra=12 at cycle n -> Qa=0x5A5A5A5A at cycle n+1,
//    not at cycle n. Sweep all 32 indices with DATA_W=32, ADDR_W=5; then repeat at DATA_W=16, ADDR_W=3.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with 2 read ports, 1 write port and a scoreboard
// holding one pending bit per register.
//
// The pending bit for a register is set when a producer issues (i_iss/i_wi)
// and cleared when that register is written back (i_we/i_wr).
//
// Parameters
//   DATA_W    register width
//   ADDR_W    index width; the file holds 2**ADDR_W registers
//   ZERO_REG  1: register 0 reads 0, ignores writes and is never pending
//   BYPASS    1: write data is forwarded to a read port with the same index
//   RD_REG    1: read data and busy flags are registered (one-cycle latency)
//
// Ports
//   i_clk              clock; all state changes on the rising edge
//   i_clr              synchronous reset, active-high
//   i_ra, i_rb         read indices
//   o_qa, o_qb         read data
//   o_busy_a/_b        the indexed register has an outstanding producer
//   i_we, i_wr, i_d    writeback enable, index and data
//   i_iss, i_wi        issue strobe and index of the register being produced
//   o_waw              the issue targets a register that is already pending
//   o_pend             pending-bit vector; bit i belongs to register i
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int RD_REG   = 0
) (
   input  logic                      i_clk,
   input  logic                      i_clr,
   input  logic [ADDR_W-1:0]         i_ra,
   input  logic [ADDR_W-1:0]         i_rb,
   output logic [DATA_W-1:0]         o_qa,
   output logic [DATA_W-1:0]         o_qb,
   output logic                      o_busy_a,
   output logic                      o_busy_b,
   input  logic                      i_we,
   input  logic [ADDR_W-1:0]         i_wr,
   input  logic [DATA_W-1:0]         i_d,
   input  logic                      i_iss,
   input  logic [ADDR_W-1:0]         i_wi,
   output logic                      o_waw,
   output logic [(1<<ADDR_W)-1:0]    o_pend
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [NREG];
   logic [NREG-1:0]   r_pend;
   logic [NREG-1:0]   w_pend_nxt;
   logic              w_wr_ok;
   logic              w_iss_ok;
   logic [DATA_W-1:0] w_qa;
   logic [DATA_W-1:0] w_qb;
   logic              w_busy_a;
   logic              w_busy_b;

   // With a hardwired zero register, writes and issues aimed at index 0 are dropped.
   assign w_wr_ok  = i_we  && !((ZERO_REG != 0) && (i_wr == '0));
   assign w_iss_ok = i_iss && !((ZERO_REG != 0) && (i_wi == '0));

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem[i_wr] <= i_d;
      end
   end

   // The writeback clear is applied before the issue set, so an issue and a
   // writeback to the same index in one cycle leave the bit set for the new producer.
   always_comb begin
      w_pend_nxt = r_pend;
      if (i_we)     w_pend_nxt[i_wr] = 1'b0;
      if (w_iss_ok) w_pend_nxt[i_wi] = 1'b1;
      if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) r_pend <= '0;
      else       r_pend <= w_pend_nxt;
   end

   assign o_pend = r_pend;
   assign o_waw  = w_iss_ok && r_pend[i_wi];

   // Effective read values. A forwarded write also hides the busy flag, because
   // the value being read is the one that resolves the hazard.
   always_comb begin
      w_qa     = r_mem[i_ra];
      w_qb     = r_mem[i_rb];
      w_busy_a = r_pend[i_ra];
      w_busy_b = r_pend[i_rb];
      if ((ZERO_REG != 0) && (i_ra == '0)) w_qa = '0;
      if ((ZERO_REG != 0) && (i_rb == '0)) w_qb = '0;
      if ((BYPASS != 0) && i_we && (i_wr == i_ra)) begin
         w_busy_a = 1'b0;
         if (w_wr_ok) w_qa = i_d;
      end
      if ((BYPASS != 0) && i_we && (i_wr == i_rb)) begin
         w_busy_b = 1'b0;
         if (w_wr_ok) w_qb = i_d;
      end
   end

   generate
      if (RD_REG != 0) begin : g_rd_reg
         logic [DATA_W-1:0] r_qa;
         logic [DATA_W-1:0] r_qb;
         logic              r_busy_a;
         logic              r_busy_b;

         always_ff @(posedge i_clk) begin
            if (i_clr) begin
               r_qa     <= '0;
               r_qb     <= '0;
               r_busy_a <= 1'b0;
               r_busy_b <= 1'b0;
            end else begin
               r_qa     <= w_qa;
               r_qb     <= w_qb;
               r_busy_a <= w_busy_a;
               r_busy_b <= w_busy_b;
            end
         end

         assign o_qa     = r_qa;
         assign o_qb     = r_qb;
         assign o_busy_a = r_busy_a;
         assign o_busy_b = r_busy_b;
      end else begin : g_rd_comb
         assign o_qa     = w_qa;
         assign o_qb     = w_qb;
         assign o_busy_a = w_busy_a;
         assign o_busy_b = w_busy_b;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for regfile_sb in four configurations:
// the default (bypass, combinational read), no bypass, registered read at
// 32x32, and registered read at 8x16.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [4:0]  ra = '0, rb = '0, wr = '0, wi = '0;
   logic        we = 1'b0, iss = 1'b0;
   logic [31:0] d = '0;

   logic [31:0] qa_d, qb_d, qa_n, qb_n, qa_r, qb_r, pend_d, pend_n, pend_r;
   logic        ba_d, bb_d, waw_d, ba_n, bb_n, waw_n, ba_r, bb_r, waw_r;
   logic [15:0] qa_s, qb_s;
   logic [7:0]  pend_s;
   logic        ba_s, bb_s, waw_s;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_sb u_dut (
      .i_clk(clk), .i_clr(clr), .i_ra(ra), .i_rb(rb), .o_qa(qa_d), .o_qb(qb_d),
      .o_busy_a(ba_d), .o_busy_b(bb_d), .i_we(we), .i_wr(wr), .i_d(d),
      .i_iss(iss), .i_wi(wi), .o_waw(waw_d), .o_pend(pend_d)
   );

   regfile_sb #(.BYPASS(0)) u_nbyp (
      .i_clk(clk), .i_clr(clr), .i_ra(ra), .i_rb(rb), .o_qa(qa_n), .o_qb(qb_n),
      .o_busy_a(ba_n), .o_busy_b(bb_n), .i_we(we), .i_wr(wr), .i_d(d),
      .i_iss(iss), .i_wi(wi), .o_waw(waw_n), .o_pend(pend_n)
   );

   regfile_sb #(.RD_REG(1)) u_rreg (
      .i_clk(clk), .i_clr(clr), .i_ra(ra), .i_rb(rb), .o_qa(qa_r), .o_qb(qb_r),
      .o_busy_a(ba_r), .o_busy_b(bb_r), .i_we(we), .i_wr(wr), .i_d(d),
      .i_iss(iss), .i_wi(wi), .o_waw(waw_r), .o_pend(pend_r)
   );

   regfile_sb #(.DATA_W(16), .ADDR_W(3), .RD_REG(1)) u_rreg16 (
      .i_clk(clk), .i_clr(clr), .i_ra(ra[2:0]), .i_rb(rb[2:0]), .o_qa(qa_s), .o_qb(qb_s),
      .o_busy_a(ba_s), .o_busy_b(bb_s), .i_we(we), .i_wr(wr[2:0]), .i_d(d[15:0]),
      .i_iss(iss), .i_wi(wi[2:0]), .o_waw(waw_s), .o_pend(pend_s)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1; we = 1'b0; iss = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   function automatic logic [31:0] pat32(input int i);
      if (i == 12) return 32'h5A5A5A5A;
      return {8'(i), 8'(~i), 8'(i + 8'h40), 8'(i ^ 8'h33)};
   endfunction

   function automatic logic [15:0] pat16(input int i);
      return 16'(i * 16'h1111 + 16'h0F0F);
   endfunction

   initial begin
      clr = 1'b1;
      tick();
      clr = 1'b0;

      // reset clears data, pending bits and registered outputs
      we = 1'b1; wr = 5'd5; d = 32'hDEADBEEF; iss = 1'b1; wi = 5'd7;
      tick();
      we = 1'b0; iss = 1'b0; ra = 5'd5;
      #1;
      chk_eq("pre_clr_qa", qa_d, 64'hDEADBEEF);
      chk_eq("pre_clr_pend", pend_d, 64'h80);
      do_clr();
      #1;
      chk_eq("clr_qa", qa_d, 0);
      chk_eq("clr_pend", pend_d, 0);
      chk_eq("clr_busy_a", ba_d, 0);
      chk_eq("clr_rreg_qa", qa_r, 0);

      // zero register ignores writes and issues
      we = 1'b1; wr = 5'd0; d = 32'h1234; iss = 1'b1; wi = 5'd0;
      #1;
      chk_eq("zero_waw", waw_d, 0);
      tick();
      we = 1'b0; iss = 1'b0; ra = 5'd0;
      #1;
      chk_eq("zero_qa", qa_d, 0);
      chk_eq("zero_pend", pend_d, 0);

      // bypass versus no bypass
      we = 1'b1; wr = 5'd3; d = 32'h11;
      tick();
      d = 32'h22; ra = 5'd3;
      #1;
      chk_eq("byp_same_cyc", qa_d, 64'h22);
      chk_eq("nbyp_same_cyc", qa_n, 64'h11);
      tick();
      we = 1'b0;
      #1;
      chk_eq("byp_next_cyc", qa_d, 64'h22);
      chk_eq("nbyp_next_cyc", qa_n, 64'h22);

      // scoreboard set, WAW detection, clear on writeback
      iss = 1'b1; wi = 5'd9;
      #1;
      chk_eq("sb_waw_first", waw_d, 0);
      tick();
      iss = 1'b0; rb = 5'd9;
      #1;
      chk_eq("sb_pend9", pend_d[9], 1);
      chk_eq("sb_busy_b", bb_d, 1);
      iss = 1'b1;
      #1;
      chk_eq("sb_waw_again", waw_d, 1);
      tick();
      iss = 1'b0;
      #1;
      chk_eq("sb_still_pend", pend_d, 64'h200);
      we = 1'b1; wr = 5'd9; d = 32'hAB;
      #1;
      chk_eq("sb_wb_busy_b", bb_d, 0);
      chk_eq("sb_wb_qb", qb_d, 64'hAB);
      chk_eq("sb_nbyp_busy_b", bb_n, 1);
      tick();
      we = 1'b0;
      #1;
      chk_eq("sb_pend_clr", pend_d[9], 0);
      chk_eq("sb_busy_b_after", bb_d, 0);
      chk_eq("sb_qb_after", qb_d, 64'hAB);

      // issue and writeback to the same index keep the bit set
      iss = 1'b1; wi = 5'd4;
      tick();
      we = 1'b1; wr = 5'd4; d = 32'hC0FFEE;
      #1;
      chk_eq("sim_waw", waw_d, 1);
      tick();
      we = 1'b0; iss = 1'b0; ra = 5'd4; rb = 5'd4;
      #1;
      chk_eq("sim_pend4", pend_d[4], 1);
      chk_eq("sim_qa", qa_d, 64'hC0FFEE);
      chk_eq("sim_qb_same_idx", qb_d, 64'hC0FFEE);
      chk_eq("sim_busy_a", ba_d, 1);
      chk_eq("sim_busy_b", bb_d, 1);

      // writeback to a non-pending register leaves the scoreboard alone
      we = 1'b1; wr = 5'd6; d = 32'h66;
      tick();
      we = 1'b0; ra = 5'd6;
      #1;
      chk_eq("np_pend", pend_d, 64'h10);
      chk_eq("np_qa", qa_d, 64'h66);

      // registered read, 32 x 32
      do_clr();
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; wr = 5'(i); d = pat32(i);
         tick();
      end
      we = 1'b0;
      ra = 5'd11;
      tick();
      ra = 5'd12;
      #1;
      chk_eq("rreg_lat_n", qa_r, {32'h0, pat32(11)});
      chk_eq("comb_lat_n", qa_d, 64'h5A5A5A5A);
      tick();
      chk_eq("rreg_lat_n1", qa_r, 64'h5A5A5A5A);
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i); rb = 5'(31 - i);
         tick();
         chk_eq("rreg_sweep_a", qa_r, (i == 0) ? 64'h0 : {32'h0, pat32(i)});
         chk_eq("rreg_sweep_b", qb_r, (i == 31) ? 64'h0 : {32'h0, pat32(31 - i)});
      end

      // registered busy follows the same one-cycle latency
      ra = 5'd12; iss = 1'b1; wi = 5'd12;
      tick();
      iss = 1'b0;
      chk_eq("rreg_busy_n", ba_r, 0);
      tick();
      chk_eq("rreg_busy_n1", ba_r, 1);

      // registered read, 8 x 16
      do_clr();
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; wr = 5'(i); d = {16'h0, pat16(i)};
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra = 5'(i); rb = 5'(7 - i);
         tick();
         chk_eq("rreg16_sweep_a", qa_s, (i == 0) ? 64'h0 : {48'h0, pat16(i)});
         chk_eq("rreg16_sweep_b", qb_s, (i == 7) ? 64'h0 : {48'h0, pat16(7 - i)});
      end
      iss = 1'b1; wi = 5'd3;
      tick();
      iss = 1'b0;
      chk_eq("rreg16_pend", pend_s, 64'h08);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
